// File: rtl/shifter_adc_pkg.sv
// Shared CSR map, command words and FSM encoding for the shifterADC sequencing controller.
package shifter_adc_pkg;

  localparam int SAMPLE_W = 12;

  localparam logic       SEQ_CMD = 1'b0;
  localparam logic [6:0] IER     = 7'd64;
  localparam logic [6:0] ISR     = 7'd65;

  localparam logic [31:0] CMD_RUN_SINGLE = 32'h0000_0003;
  localparam logic [31:0] CMD_STOP       = 32'h0000_0000;
  localparam logic [31:0] IRQ_EOP        = 32'h0000_0001;

  typedef enum logic [3:0] {
    IDLE,
    ARM_IER,
    START,
    WAIT_IRQ,
    READ_ISSUE,
    READ_WAIT,
    CLEAR_ISR,
    PUBLISH,
    STOP
  } state_e;

endpackage

// File: rtl/shifter_adc_scheduler.sv
// Sequences single-cycle conversions on the shifterADC core, reads back every slot
// after each end-of-sequence IRQ and publishes a coherent multi-channel snapshot.
module shifter_adc_scheduler
  import shifter_adc_pkg::*;
#(
  parameter int NUM_SLOTS      = 2,
  parameter int READ_LAT       = 2,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                         clock_clk,
  input  logic                         reset_sink_reset,
  input  logic                         enable,
  output logic                         sequencer_csr_address,
  output logic                         sequencer_csr_read,
  output logic                         sequencer_csr_write,
  output logic [31:0]                  sequencer_csr_writedata,
  output logic [6:0]                   sample_store_csr_address,
  output logic                         sample_store_csr_read,
  output logic                         sample_store_csr_write,
  output logic [31:0]                  sample_store_csr_writedata,
  input  logic [31:0]                  sample_store_csr_readdata,
  input  logic                         sample_store_irq_irq,
  output logic [SAMPLE_W*NUM_SLOTS-1:0] sample_data,
  output logic                         sample_valid,
  output logic [15:0]                  seq_count,
  output logic                         timeout_err
);

  localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int LAT_W  = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
  localparam int TMO_W  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_SLOTS - 1);
  localparam logic [LAT_W-1:0]  LAST_LAT  = LAT_W'(READ_LAT - 1);
  localparam logic [TMO_W-1:0]  LAST_TMO  = TMO_W'(TIMEOUT_CYCLES - 1);

  state_e                       state_q, state_d;
  logic                         armed_q;
  logic [SLOT_W-1:0]            slot_q, slot_d;
  logic [LAT_W-1:0]             lat_q;
  logic [TMO_W-1:0]             tmo_q;
  logic [SAMPLE_W-1:0]          shadow_q [NUM_SLOTS];
  logic [SAMPLE_W*NUM_SLOTS-1:0] snapshot;
  logic                         read_done;

  logic                         seq_wr_d;
  logic [31:0]                  seq_wd_d;
  logic [6:0]                   ss_addr_d;
  logic                         ss_rd_d;
  logic                         ss_wr_d;
  logic [31:0]                  ss_wd_d;

  // The sequencer is only ever written, always at its command register.
  assign sequencer_csr_address = SEQ_CMD;
  assign sequencer_csr_read    = 1'b0;

  // Only the low sample bits of the read word carry conversion data.
  logic unused_readdata_hi;
  assign unused_readdata_hi = ^sample_store_csr_readdata[31:SAMPLE_W];

  assign read_done = (state_q == READ_WAIT) && (lat_q == LAST_LAT);

  always_ff @(posedge clock_clk) begin
    if (reset_sink_reset) state_q <= IDLE;
    else                  state_q <= state_d;
  end

  // Strobes are decoded from the next state and registered, so each one lines up with its state.
  always_comb begin
    // NOTE: every variable gets a default first so no path through the case infers a latch.
    state_d   = state_q;
    slot_d    = slot_q;
    seq_wr_d  = 1'b0;
    seq_wd_d  = '0;
    ss_addr_d = '0;
    ss_rd_d   = 1'b0;
    ss_wr_d   = 1'b0;
    ss_wd_d   = '0;

    unique case (state_q)
      IDLE:       if (enable) state_d = armed_q ? START : ARM_IER;
      ARM_IER:    state_d = START;
      START:      state_d = WAIT_IRQ;
      WAIT_IRQ: begin
        if (sample_store_irq_irq) begin
          state_d = READ_ISSUE;
          slot_d  = '0;
        end else if (tmo_q == LAST_TMO) begin
          state_d = STOP;
        end
      end
      READ_ISSUE: state_d = READ_WAIT;
      READ_WAIT: begin
        if (read_done) begin
          state_d = (slot_q == LAST_SLOT) ? CLEAR_ISR : READ_ISSUE;
          slot_d  = slot_q + SLOT_W'(1);
        end
      end
      CLEAR_ISR:  state_d = PUBLISH;
      PUBLISH:    state_d = enable ? START : IDLE;
      STOP:       state_d = IDLE;
      default:    state_d = IDLE;
    endcase

    unique case (state_d)
      ARM_IER: begin
        ss_wr_d   = 1'b1;
        ss_addr_d = IER;
        ss_wd_d   = IRQ_EOP;
      end
      START: begin
        seq_wr_d = 1'b1;
        seq_wd_d = CMD_RUN_SINGLE;
      end
      READ_ISSUE: begin
        ss_rd_d   = 1'b1;
        ss_addr_d = 7'(slot_d);
      end
      CLEAR_ISR: begin
        ss_wr_d   = 1'b1;
        ss_addr_d = ISR;
        ss_wd_d   = IRQ_EOP;
      end
      STOP: begin
        seq_wr_d = 1'b1;
        seq_wd_d = CMD_STOP;
      end
      default: ;
    endcase
  end

  always_comb begin
    snapshot = '0;
    for (int i = 0; i < NUM_SLOTS; i++) snapshot[i*SAMPLE_W +: SAMPLE_W] = shadow_q[i];
  end

  // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clock_clk) begin
    if (reset_sink_reset) begin
      sequencer_csr_write        <= 1'b0;
      sequencer_csr_writedata    <= '0;
      sample_store_csr_address   <= '0;
      sample_store_csr_read      <= 1'b0;
      sample_store_csr_write     <= 1'b0;
      sample_store_csr_writedata <= '0;
      sample_data                <= '0;
      sample_valid               <= 1'b0;
      seq_count                  <= '0;
      timeout_err                <= 1'b0;
      armed_q                    <= 1'b0;
      slot_q                     <= '0;
      lat_q                      <= '0;
      tmo_q                      <= '0;
    end else begin
      sequencer_csr_write        <= seq_wr_d;
      sequencer_csr_writedata    <= seq_wd_d;
      sample_store_csr_address   <= ss_addr_d;
      sample_store_csr_read      <= ss_rd_d;
      sample_store_csr_write     <= ss_wr_d;
      sample_store_csr_writedata <= ss_wd_d;
      slot_q                     <= slot_d;
      lat_q                      <= (state_q == READ_WAIT) ? lat_q + LAT_W'(1) : '0;
      tmo_q                      <= (state_q == WAIT_IRQ) ? tmo_q + TMO_W'(1) : '0;
      sample_valid               <= (state_d == PUBLISH);
      if (state_d == ARM_IER) armed_q <= 1'b1;
      if (state_d == STOP)    timeout_err <= 1'b1;
      if (state_d == PUBLISH) begin
        sample_data <= snapshot;
        seq_count   <= seq_count + 16'd1;
      end
    end
  end

  // NOTE: the shadow slots carry no reset; every slot is rewritten before PUBLISH reads them.
  always_ff @(posedge clock_clk) begin
    if (read_done) shadow_q[slot_q] <= sample_store_csr_readdata[SAMPLE_W-1:0];
  end

endmodule
